// File: rtl/if_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl_pkg
// Shared definitions for the instruction-fetch sequencer: bus widths, the
// fetch FSM state encodings, the hold-buffer entry layout and a helper that
// extracts the fetch address-error (AdEL) flag from an excepttype word.
// -----------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

   // Bus widths
   localparam int PC_TO_IC_WD  = 65;  // {excepttype[31:0], ce, pc[31:0]}
   localparam int STALL_BUS_WD = 6;
   localparam int IF_TO_ID_WD  = 97;  // {if_valid, if_pc, if_inst, if_excepttype}

   // Bit of excepttype flagging a misaligned / illegal fetch address
   localparam int ADEL_BIT = 16;

   // Fetch FSM state encodings
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REQ    = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
   localparam logic [2:0] S_CANCEL = 3'd4;

   // One returned instruction together with its pc and excepttype
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] excepttype;
   } hold_entry_t;

   // True when the fetch address already carries an address-error exception
   function automatic logic fetch_adel(input logic [31:0] excepttype);
      return excepttype[ADEL_BIT];
   endfunction

endpackage

// File: rtl/if_hold_buf.sv
// -----------------------------------------------------------------------------
// if_hold_buf
// 96-bit load/clear register that parks a returned instruction while decode
// is stalled.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - capture din on the next edge
//   clr       - clear to zero on the next edge (wins over load)
//   din       - {pc, inst, excepttype} to capture
//   dout      - current buffer contents
// -----------------------------------------------------------------------------
module if_hold_buf
   import if_fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clr,
   input  hold_entry_t din,
   output hold_entry_t dout
);

   hold_entry_t buf_d;
   hold_entry_t buf_q;

   // Next buffer value: clear, capture or keep
   always_comb begin
      buf_d = buf_q;
      if (clr) begin
         buf_d = hold_entry_t'(96'd0);
      end else if (load) begin
         buf_d = din;
      end else begin
         buf_d = buf_q;
      end
   end

   // Buffer storage
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q <= hold_entry_t'(96'd0);
      end else begin
         buf_q <= buf_d;
      end
   end

   assign dout = buf_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch sequencer between the PC register and an SRAM-like
// instruction bus. Keeps one fetch outstanding, freezes the PC while the fetch
// is in flight, buffers a returned instruction while decode is stalled and
// discards fetches made stale by a flush.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   pc_to_ic_bus      - {excepttype[31:0], ce, pc[31:0]} from the PC stage
//   stall             - pipeline stall bus, stall[1] = decode cannot accept
//   flush             - exception / eret flush
//   inst_req/addr     - bus request and address
//   inst_addr_ok      - bus accepted the address
//   inst_data_ok      - read data valid, inst_rdata carries it
//   stallreq_for_if   - freeze PC and upstream pipeline
//   if_valid/pc/inst/excepttype - instruction presented to decode
// -----------------------------------------------------------------------------
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'hbfc0_0000
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PC_TO_IC_WD-1:0]  pc_to_ic_bus,
   input  logic [STALL_BUS_WD-1:0] stall,
   input  logic                    flush,
   output logic                    inst_req,
   output logic [31:0]             inst_addr,
   input  logic                    inst_addr_ok,
   input  logic                    inst_data_ok,
   input  logic [31:0]             inst_rdata,
   output logic                    stallreq_for_if,
   output logic                    if_valid,
   output logic [31:0]             if_pc,
   output logic [31:0]             if_inst,
   output logic [31:0]             if_excepttype
);

   logic [31:0] pc_s;
   logic [31:0] excepttype_s;
   logic        ce_s;
   logic        adel_s;
   logic        stall_id_s;

   assign pc_s         = pc_to_ic_bus[31:0];
   assign ce_s         = pc_to_ic_bus[32];
   assign excepttype_s = pc_to_ic_bus[64:33];
   assign adel_s       = fetch_adel(excepttype_s);
   assign stall_id_s   = stall[1];

   // RESET_PC is informational; remaining stall bits belong to other stages
   logic unused_s;
   assign unused_s = ^{RESET_PC, stall[5:2], stall[0]};

   logic [2:0]  state_d;
   logic [2:0]  state_q;
   logic        req_s;
   logic        stallreq_s;
   logic        present_s;      // present the live pc/rdata this cycle
   logic        present_buf_s;  // present the hold buffer this cycle
   logic        buf_load_s;
   logic        buf_clr_s;
   hold_entry_t live_s;
   hold_entry_t buf_dout_s;

   if_hold_buf u_hold_buf (
      .clk  (clk),
      .rst  (rst),
      .load (buf_load_s),
      .clr  (buf_clr_s),
      .din  (live_s),
      .dout (buf_dout_s)
   );

   // Fetch FSM: next state, bus request, stall request and buffer control
   always_comb begin
      state_d       = state_q;
      req_s         = 1'b0;
      stallreq_s    = 1'b0;
      present_s     = 1'b0;
      present_buf_s = 1'b0;
      buf_load_s    = 1'b0;
      buf_clr_s     = 1'b0;
      live_s        = '{pc: pc_s, inst: inst_rdata, excepttype: excepttype_s};
      case (state_q)
         S_IDLE: begin
            if (ce_s) begin
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (adel_s) begin
               // Bad fetch address: no bus access, the exception itself is
               // handed to decode as if it were returned data with inst 0.
               live_s.inst = 32'd0;
               if (flush) begin
                  state_d = S_IDLE;
               end else if (stall_id_s) begin
                  buf_load_s = 1'b1;
                  state_d    = S_HOLD;
               end else begin
                  present_s = 1'b1;
                  state_d   = S_REQ;
               end
            end else begin
               req_s      = 1'b1;
               stallreq_s = 1'b1;
               if (inst_addr_ok) begin
                  state_d = flush ? S_CANCEL : S_WAIT;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_WAIT: begin
            if (inst_data_ok) begin
               if (flush) begin
                  state_d = S_IDLE;
               end else if (stall_id_s) begin
                  buf_load_s = 1'b1;
                  state_d    = S_HOLD;
               end else begin
                  present_s = 1'b1;
                  state_d   = S_REQ;
               end
            end else begin
               stallreq_s = 1'b1;
               state_d    = flush ? S_CANCEL : S_WAIT;
            end
         end
         S_HOLD: begin
            if (flush) begin
               buf_clr_s = 1'b1;
               state_d   = S_IDLE;
            end else if (stall_id_s) begin
               present_buf_s = 1'b1;
               state_d       = S_HOLD;
            end else begin
               present_buf_s = 1'b1;
               buf_clr_s     = 1'b1;
               state_d       = S_REQ;
            end
         end
         S_CANCEL: begin
            // The outstanding fetch is stale; swallow its data_ok.
            stallreq_s = 1'b1;
            if (inst_data_ok) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_CANCEL;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs toward the bus and decode
   always_comb begin
      inst_req        = req_s;
      inst_addr       = req_s ? pc_s : 32'd0;
      stallreq_for_if = stallreq_s;
      if (present_s) begin
         if_valid      = 1'b1;
         if_pc         = live_s.pc;
         if_inst       = live_s.inst;
         if_excepttype = live_s.excepttype;
      end else if (present_buf_s) begin
         if_valid      = 1'b1;
         if_pc         = buf_dout_s.pc;
         if_inst       = buf_dout_s.inst;
         if_excepttype = buf_dout_s.excepttype;
      end else begin
         if_valid      = 1'b0;
         if_pc         = 32'd0;
         if_inst       = 32'd0;
         if_excepttype = 32'd0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Self-checking bench: models the PC register and the instruction bus slave,
// pushes each expected presented instruction into a queue when its data is
// driven, and pops/compares it when the DUT presents it.
// -----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] pc;
   logic [31:0] exc;
   logic        ce;
   logic [5:0]  stall;
   logic        flush;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic [64:0] pc_to_ic_bus;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic        stallreq_for_if;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [31:0] if_excepttype;

   assign pc_to_ic_bus = {exc, ce, pc};

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] exc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   if_fetch_ctrl #(.RESET_PC(32'hbfc0_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc_to_ic_bus    (pc_to_ic_bus),
      .stall           (stall),
      .flush           (flush),
      .inst_req        (inst_req),
      .inst_addr       (inst_addr),
      .inst_addr_ok    (addr_ok),
      .inst_data_ok    (data_ok),
      .inst_rdata      (rdata),
      .stallreq_for_if (stallreq_for_if),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_inst         (if_inst),
      .if_excepttype   (if_excepttype)
   );

   // Reset the DUT and return at posedge+1 with the FSM in IDLE
   task automatic apply_reset;
      @(posedge clk); #1;
      rst = 1'b1; ce = 1'b0; pc = 32'd0; exc = 32'd0; stall = 6'd0;
      flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      apply_reset();
      pc = 32'hbfc0_0000; ce = 1'b1;
      @(posedge clk); #1;                 // REQ
      @(negedge clk);
      checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", inst_req); end
      @(posedge clk); #1;
      rst = 1'b1;                         // reset mid-transaction
      @(posedge clk); #1;                 // now IDLE under reset
      @(negedge clk);
      checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", inst_req); end
      checks++; if (inst_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", inst_addr); end
      checks++; if (stallreq_for_if !== 1'b0) begin errors++; $display("FAIL rst_stallreq: got %b want 0", stallreq_for_if); end
      checks++; if ({if_valid, if_pc, if_inst, if_excepttype} !== 97'd0) begin errors++; $display("FAIL rst_if: got %b %h %h %h want all 0", if_valid, if_pc, if_inst, if_excepttype); end
      @(posedge clk); #1;
      rst = 1'b0; ce = 1'b0;
      @(negedge clk);
      checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rst_idle_req: got %b want 0", inst_req); end
   endtask

   task automatic test_basic;
      apply_reset();
      pc = 32'hbfc0_0000; ce = 1'b1;
      @(negedge clk);                     // IDLE
      checks++; if (inst_req !== 1'b0 || stallreq_for_if !== 1'b0) begin errors++; $display("FAIL basic_idle: req=%b stallreq=%b want 0 0", inst_req, stallreq_for_if); end
      @(posedge clk); #1;                 // REQ
      addr_ok = 1'b1;
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000) begin errors++; $display("FAIL basic_req: req=%b addr=%h want 1 bfc00000", inst_req, inst_addr); end
      checks++; if (stallreq_for_if !== 1'b1) begin errors++; $display("FAIL basic_req_stall: got %b want 1", stallreq_for_if); end
      @(posedge clk); #1;                 // WAIT with data
      addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h2402_0001;
      exp_q.push_back('{pc: pc, inst: rdata, exc: exc});
      @(negedge clk);
      checks++; if (inst_req !== 1'b0 || stallreq_for_if !== 1'b0) begin errors++; $display("FAIL basic_data_ctl: req=%b stallreq=%b want 0 0", inst_req, stallreq_for_if); end
      checks++;
      if (if_valid !== 1'b1 || exp_q.size() == 0) begin errors++; $display("FAIL basic_valid: if_valid=%b queued=%0d want 1", if_valid, exp_q.size()); end
      else begin
         e = exp_q.pop_front();
         checks++; if ({if_pc, if_inst, if_excepttype} !== e) begin errors++; $display("FAIL basic_data: got %h %h %h want %h", if_pc, if_inst, if_excepttype, e); end
      end
      @(posedge clk); #1;                 // PC advances, back in REQ
      data_ok = 1'b0; pc = pc + 32'd4;
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0004) begin errors++; $display("FAIL basic_next: req=%b addr=%h want 1 bfc00004", inst_req, inst_addr); end
   endtask

   task automatic test_addr_delay;
      apply_reset();
      pc = 32'hbfc0_0100; ce = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         addr_ok = (i == 3) ? 1'b1 : 1'b0;
         @(negedge clk);
         checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0100 || stallreq_for_if !== 1'b1) begin errors++; $display("FAIL delay_req%0d: req=%b addr=%h stallreq=%b want 1 bfc00100 1", i, inst_req, inst_addr, stallreq_for_if); end
      end
      @(posedge clk); #1;                 // WAIT, no data yet
      addr_ok = 1'b0;
      @(negedge clk);
      checks++; if (stallreq_for_if !== 1'b1 || if_valid !== 1'b0 || inst_req !== 1'b0) begin errors++; $display("FAIL delay_wait: stallreq=%b valid=%b req=%b want 1 0 0", stallreq_for_if, if_valid, inst_req); end
      @(posedge clk); #1;
      data_ok = 1'b1; rdata = 32'h3c1d_8001;
      exp_q.push_back('{pc: pc, inst: rdata, exc: exc});
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || exp_q.size() == 0) begin errors++; $display("FAIL delay_valid: if_valid=%b queued=%0d want 1", if_valid, exp_q.size()); end
      else begin
         e = exp_q.pop_front();
         checks++; if ({if_pc, if_inst, if_excepttype} !== e) begin errors++; $display("FAIL delay_data: got %h %h %h want %h", if_pc, if_inst, if_excepttype, e); end
      end
   endtask

   task automatic test_hold;
      apply_reset();
      pc = 32'hbfc0_0200; exc = 32'h0000_0400; ce = 1'b1;
      @(posedge clk); #1;                 // REQ
      addr_ok = 1'b1;
      @(posedge clk); #1;                 // WAIT, data while decode stalled
      addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h8c43_0004; stall = 6'b000010;
      exp_q.push_back('{pc: pc, inst: rdata, exc: exc});
      @(negedge clk);
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL hold_latch_valid: got %b want 0", if_valid); end
      @(posedge clk); #1;                 // HOLD, still stalled
      data_ok = 1'b0; rdata = 32'hdead_beef;
      @(negedge clk);
      checks++; if (stallreq_for_if !== 1'b0 || inst_req !== 1'b0) begin errors++; $display("FAIL hold_ctl: stallreq=%b req=%b want 0 0", stallreq_for_if, inst_req); end
      checks++;
      if (if_valid !== 1'b1 || exp_q.size() == 0) begin errors++; $display("FAIL hold_valid1: if_valid=%b queued=%0d want 1", if_valid, exp_q.size()); end
      else begin
         checks++; if ({if_pc, if_inst, if_excepttype} !== exp_q[0]) begin errors++; $display("FAIL hold_data1: got %h %h %h want %h", if_pc, if_inst, if_excepttype, exp_q[0]); end
      end
      @(posedge clk); #1;                 // HOLD, stall released
      stall = 6'd0;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || exp_q.size() == 0) begin errors++; $display("FAIL hold_valid2: if_valid=%b queued=%0d want 1", if_valid, exp_q.size()); end
      else begin
         e = exp_q.pop_front();
         checks++; if ({if_pc, if_inst, if_excepttype} !== e) begin errors++; $display("FAIL hold_data2: got %h %h %h want %h", if_pc, if_inst, if_excepttype, e); end
      end
      @(posedge clk); #1;                 // REQ for pc+4
      pc = pc + 32'd4;
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0204 || if_valid !== 1'b0) begin errors++; $display("FAIL hold_next: req=%b addr=%h valid=%b want 1 bfc00204 0", inst_req, inst_addr, if_valid); end
   endtask

   task automatic test_flush_wait;
      apply_reset();
      pc = 32'hbfc0_0300; ce = 1'b1;
      @(posedge clk); #1;                 // REQ
      addr_ok = 1'b1;
      @(posedge clk); #1;                 // WAIT, flush before data
      addr_ok = 1'b0; flush = 1'b1;
      @(negedge clk);
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fw_flush_valid: got %b want 0", if_valid); end
      @(posedge clk); #1;                 // CANCEL, PC loaded new_pc
      flush = 1'b0; pc = 32'hbfc0_0380;
      @(negedge clk);
      checks++; if (stallreq_for_if !== 1'b1 || inst_req !== 1'b0) begin errors++; $display("FAIL fw_cancel: stallreq=%b req=%b want 1 0", stallreq_for_if, inst_req); end
      @(posedge clk); #1;                 // stale data arrives
      data_ok = 1'b1; rdata = 32'h1234_5678;
      @(negedge clk);
      checks++; if (if_valid !== 1'b0 || if_inst !== 32'd0 || inst_req !== 1'b0) begin errors++; $display("FAIL fw_drop: valid=%b inst=%h req=%b want 0 0 0", if_valid, if_inst, inst_req); end
      @(posedge clk); #1;                 // IDLE
      data_ok = 1'b0;
      @(negedge clk);
      checks++; if (inst_req !== 1'b0 || stallreq_for_if !== 1'b0) begin errors++; $display("FAIL fw_idle: req=%b stallreq=%b want 0 0", inst_req, stallreq_for_if); end
      @(posedge clk); #1;                 // REQ to new_pc
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0380) begin errors++; $display("FAIL fw_newpc: req=%b addr=%h want 1 bfc00380", inst_req, inst_addr); end
   endtask

   task automatic test_flush_data;
      apply_reset();
      pc = 32'hbfc0_0400; ce = 1'b1;
      @(posedge clk); #1;                 // REQ
      addr_ok = 1'b1;
      @(posedge clk); #1;                 // WAIT, flush with data
      addr_ok = 1'b0; data_ok = 1'b1; flush = 1'b1; rdata = 32'h0000_000c;
      @(negedge clk);
      checks++; if (if_valid !== 1'b0 || if_inst !== 32'd0) begin errors++; $display("FAIL fd_drop: valid=%b inst=%h want 0 0", if_valid, if_inst); end
      @(posedge clk); #1;                 // IDLE, not CANCEL
      data_ok = 1'b0; flush = 1'b0; pc = 32'hbfc0_0380;
      @(negedge clk);
      checks++; if (stallreq_for_if !== 1'b0 || inst_req !== 1'b0) begin errors++; $display("FAIL fd_idle: stallreq=%b req=%b want 0 0", stallreq_for_if, inst_req); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0380) begin errors++; $display("FAIL fd_newpc: req=%b addr=%h want 1 bfc00380", inst_req, inst_addr); end
   endtask

   task automatic test_adel;
      apply_reset();
      pc = 32'hbfc0_0002; exc = 32'h0001_0000; ce = 1'b1;
      @(posedge clk); #1;                 // REQ with AdEL
      exp_q.push_back('{pc: pc, inst: 32'd0, exc: exc});
      @(negedge clk);
      checks++; if (inst_req !== 1'b0 || stallreq_for_if !== 1'b0) begin errors++; $display("FAIL adel_ctl: req=%b stallreq=%b want 0 0", inst_req, stallreq_for_if); end
      checks++;
      if (if_valid !== 1'b1 || exp_q.size() == 0) begin errors++; $display("FAIL adel_valid: if_valid=%b queued=%0d want 1", if_valid, exp_q.size()); end
      else begin
         e = exp_q.pop_front();
         checks++; if ({if_pc, if_inst, if_excepttype} !== e) begin errors++; $display("FAIL adel_data: got %h %h %h want %h", if_pc, if_inst, if_excepttype, e); end
      end
   endtask

   task automatic test_back_to_back;
      apply_reset();
      pc = 32'hbfc0_0500; ce = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;              // REQ, immediate addr_ok
         if (i != 0) pc = pc + 32'd4;
         addr_ok = 1'b1; data_ok = 1'b0;
         @(negedge clk);
         checks++; if (inst_req !== 1'b1 || inst_addr !== pc) begin errors++; $display("FAIL b2b_req%0d: req=%b addr=%h want 1 %h", i, inst_req, inst_addr, pc); end
         @(posedge clk); #1;              // WAIT, data next cycle
         addr_ok = 1'b0; data_ok = 1'b1; rdata = $urandom;
         exp_q.push_back('{pc: pc, inst: rdata, exc: exc});
         @(negedge clk);
         checks++;
         if (if_valid !== 1'b1 || exp_q.size() == 0) begin errors++; $display("FAIL b2b_valid%0d: if_valid=%b queued=%0d want 1", i, if_valid, exp_q.size()); end
         else begin
            e = exp_q.pop_front();
            checks++; if ({if_pc, if_inst, if_excepttype} !== e) begin errors++; $display("FAIL b2b_data%0d: got %h %h %h want %h", i, if_pc, if_inst, if_excepttype, e); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; pc = 32'd0; exc = 32'd0; stall = 6'd0;
      flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
      test_reset();
      test_basic();
      test_addr_delay();
      test_hold();
      test_flush_wait();
      test_flush_data();
      test_adel();
      test_back_to_back();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d entries left want 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer between the PC register and the SRAM-like instruction bus. It consumes the PC's `pc_to_ic_bus` and issues one outstanding fetch at a time. It freezes the PC through a stall request while a fetch is in flight and buffers a returned instruction while decode is stalled. It also drops in-flight fetches that a pipeline flush has made stale.

## Interface
Parameters
- `RESET_PC`, 32'hbfc0_0000: informational only; no functional use.

Ports
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `pc_to_ic_bus` in 65: {excepttype[31:0] (bit 16 = fetch AdEL), ce, pc[31:0]}.
- `stall` in 6: pipeline stall bus. `stall[1]`=1 means decode cannot accept.
- `flush` in 1: exception/eret flush.
- `inst_req` out 1: bus request.
- `inst_addr` out 32: request address (= pc).
- `inst_addr_ok` in 1: address accepted.
- `inst_data_ok` in 1: read data valid.
- `inst_rdata` in 32: read data.
- `stallreq_for_if` out 1: freeze PC and the upstream pipeline.
- `if_valid` out 1: instruction presented to decode this cycle.
- `if_pc` out 32: PC of the presented instruction.
- `if_inst` out 32: the presented instruction.
- `if_excepttype` out 32: excepttype carried with the instruction.

## Operation
- States: IDLE, REQ, WAIT, HOLD, CANCEL.
- IDLE: if ce=1, go to REQ.
- REQ, adel=0:
  - `inst_req`=1 and `inst_addr`=pc.
  - `inst_req` is held until `inst_addr_ok`; it is never withdrawn.
  - On req&addr_ok: go to CANCEL if flush=1, else WAIT.
- REQ, adel=1:
  - No bus request.
  - The PC is presented this cycle with `if_inst`=0 and the excepttype forwarded. This counts as data returned.
- WAIT:
  - data_ok & flush: go to IDLE; the data is discarded.
  - data_ok & !flush & stall[1]=0: present the data, then go to REQ.
  - data_ok & !flush & stall[1]=1: latch {pc, rdata, excepttype} into the hold buffer, then go to HOLD.
  - !data_ok & flush: go to CANCEL.
- HOLD:
  - Present the buffer.
  - flush: go to IDLE.
  - stall[1]=0: the buffer is consumed, then go to REQ.
- CANCEL: on data_ok, drop the data and go to IDLE. flush has no further effect here.
- "Present" with !flush gives:
  - `if_valid`=1.
  - `if_pc` = pc (or the buffered pc in HOLD).
  - `if_inst` = rdata (or the buffer in HOLD).
  - `if_excepttype` = excepttype (or the buffer in HOLD).
- In every other cycle, `if_valid`=0 and `if_inst`=0.
- `stallreq_for_if`=1 in:
  - REQ when adel=0;
  - WAIT without data_ok;
  - CANCEL.
- `stallreq_for_if`=0 otherwise: IDLE, HOLD, and cycles where data is presented.
- After a flush the PC loads `new_pc`. IDLE then sees ce=1 and issues the new fetch.

## Timing
- Reset values: state=IDLE; all outputs 0; hold buffer 0.
- Reset mid-transaction: go to IDLE immediately. The bus slave is reset on the same `rst`, so no stale data_ok follows.
- Minimum fetch latency is 2 cycles: REQ with addr_ok, then WAIT with data_ok.
- Zero-wait-state throughput is 1 instruction per 2 cycles.
- `inst_data_ok` is never accepted in the same cycle as its own `inst_addr_ok`.
- Only one transaction is outstanding; a second `inst_req` is never raised before the first data_ok.
- PC advances exactly on the edge that ends a present cycle with stall[1]=0. The next state is REQ with the new pc.
- Simultaneous flush and data_ok in WAIT: the data is dropped, `if_valid`=0, and the next state is IDLE. No CANCEL is needed.
- `inst_req`, `stallreq_for_if` and `if_*` are combinational from state and inputs. The state and hold buffer are registered.

## Structure
- Shared defines header holds:
  - state encodings (3 bits);
  - `PC_TO_IC_WD`=65;
  - `StallBus` width 6;
  - the adel excepttype bit index 16;
  - an `IF_TO_ID_WD`=97 bus width, for an optional packed form of the `if_*` outputs.
- Sub-module `if_hold_buf`: a 96-bit load/clear register for pc, inst and excepttype.

## Test plan
- Reset, then ce=1 with pc=bfc00000, addr_ok immediate, data_ok next cycle with rdata=24020001:
  - inst_req=1 for exactly 1 cycle;
  - if_valid=1, if_inst=24020001, if_pc=bfc00000;
  - stallreq_for_if high only during the REQ and WAIT cycles before the data.
- addr_ok delayed 3 cycles:
  - inst_req and inst_addr stable for all 4 cycles;
  - PC unchanged throughout.
- stall[1]=1 held 2 cycles when data_ok arrives:
  - state enters HOLD and if_valid is held on the buffered instruction;
  - on stall release the next fetch is for pc+4.
- flush in WAIT before data_ok (flush with new_pc=bfc00380):
  - the later data_ok is dropped with if_valid=0;
  - the next inst_addr is bfc00380.
- flush coinciding with data_ok:
  - if_valid=0;
  - the next state is IDLE, with no CANCEL cycle.
- pc=bfc00002:
  - no inst_req;
  - if_valid=1, if_inst=0, if_excepttype=00010000.
